// File: rtl/rise_detector.sv
`default_nettype none
// ============================================================================
// Module   : rise_detector
// Purpose  : Conditions a raw asynchronous input into a filtered level and
//            one-cycle rise/glitch (and optionally fall) strobes.
//            Optional macro EDGE_FALL_OUT_EN adds the fall strobe port.
// Revision : 1.0 - initial release
// ============================================================================
module rise_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enb,
  input  logic din,
  output logic rise,
  output logic level,
`ifdef EDGE_FALL_OUT_EN
  output logic fall,
`endif
  output logic glitch
);

  localparam int            CW        = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] c_cnt_max = CW'(FILTER_LEN);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CONF_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CONF_L = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_din_s;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic r_rise;
  logic r_level;
  logic r_glitch;
  logic w_rise_nxt;
  logic w_level_nxt;
  logic w_glitch_nxt;
`ifdef EDGE_FALL_OUT_EN
  logic r_fall;
  logic w_fall_nxt;
`endif

  // Synchronizer is cleared with enb so a re-enable always sees a fresh window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else if (!enb) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_din_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rise_nxt   = 1'b0;
    w_glitch_nxt = 1'b0;
`ifdef EDGE_FALL_OUT_EN
    w_fall_nxt   = 1'b0;
`endif
    case (r_state)
      ST_LOW: begin
        if (w_din_s) begin
          w_state_nxt = ST_CONF_H;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_CONF_H: begin
        if (!w_din_s) begin
          w_state_nxt  = ST_LOW;
          w_cnt_nxt    = '0;
          w_glitch_nxt = 1'b1;
        end else if (r_cnt >= c_cnt_max) begin
          w_state_nxt  = ST_HIGH;
          w_cnt_nxt    = '0;
          w_rise_nxt   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + c_cnt_one;
        end
      end
      ST_HIGH: begin
        if (!w_din_s) begin
          w_state_nxt = ST_CONF_L;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_CONF_L: begin
        if (w_din_s) begin
          w_state_nxt  = ST_HIGH;
          w_cnt_nxt    = '0;
          w_glitch_nxt = 1'b1;
        end else if (r_cnt >= c_cnt_max) begin
          // Accepted fall: level clears even when no fall strobe is built
          w_state_nxt  = ST_LOW;
          w_cnt_nxt    = '0;
`ifdef EDGE_FALL_OUT_EN
          w_fall_nxt   = 1'b1;
`endif
        end else begin
          w_cnt_nxt    = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_CONF_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_LOW;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_level  <= 1'b0;
      r_glitch <= 1'b0;
    end else if (!enb) begin
      r_state  <= ST_LOW;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_level  <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rise   <= w_rise_nxt;
      r_level  <= w_level_nxt;
      r_glitch <= w_glitch_nxt;
    end
  end

`ifdef EDGE_FALL_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall <= 1'b0;
    end else if (!enb) begin
      r_fall <= 1'b0;
    end else begin
      r_fall <= w_fall_nxt;
    end
  end

  assign fall = r_fall;
`endif

  assign rise   = r_rise;
  assign level  = r_level;
  assign glitch = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_rise_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rise_detector
// Purpose  : Scoreboard bench for rise_detector: expected strobes are queued
//            with their edge number as stimulus is driven, and popped when seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rise_detector;

  logic clk = 1'b0;
  logic rst_n;
  logic enb;
  logic din;
  logic rise;
  logic level;
  logic glitch;
  logic fall;

  localparam int c_kind_rise   = 1;
  localparam int c_kind_glitch = 2;
  localparam int c_kind_fall   = 3;

  typedef struct {
    int kind;
    int edge_n;
  } ev_t;

  ev_t sb[$];
  int  total    = 0;
  int  bad      = 0;
  int  cyc      = 0;
  int  rise_cnt = 0;
  int  mon_kind;
  ev_t mon_ev;

  rise_detector #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enb    (enb),
    .din    (din),
    .rise   (rise),
    .level  (level),
`ifdef EDGE_FALL_OUT_EN
    .fall   (fall),
`endif
    .glitch (glitch)
  );

`ifndef EDGE_FALL_OUT_EN
  assign fall = 1'b0;
`endif

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic expect_ev(input int kind, input int e);
    sb.push_back('{kind: kind, edge_n: e});
  endtask

  task automatic expect_fall(input int e);
`ifdef EDGE_FALL_OUT_EN
    expect_ev(c_kind_fall, e);
`else
    if (e < 0) $display("negative edge %0d", e);
`endif
  endtask

  // Pulse monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (rise) rise_cnt++;
    check("exclusive", 32'((32'(rise) + 32'(glitch) + 32'(fall)) <= 1), 32'd1);
    mon_kind = rise ? c_kind_rise : glitch ? c_kind_glitch : fall ? c_kind_fall : 0;
    if (mon_kind != 0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", mon_kind, 0);
      end else begin
        mon_ev = sb.pop_front();
        check("pulse_kind", mon_kind, mon_ev.kind);
        check("pulse_edge", cyc, mon_ev.edge_n);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int r0;
    rst_n = 1'b0;
    enb   = 1'b1;
    din   = 1'b1;
    tick(3);
    check("rst_rise",   rise,   0);
    check("rst_level",  level,  0);
    check("rst_glitch", glitch, 0);
    check("rst_fall",   fall,   0);

    // Release reset with din already high
    rst_n = 1'b1;
    k = cyc + 1;
    expect_ev(c_kind_rise, k + 6);
    wait_edge(k + 5); check("t1_level_pre",  level, 0);
    wait_edge(k + 6); check("t1_level_post", level, 1);
    tick(3);          check("t1_level_hold", level, 1);

    // Short low excursion while high aborts
    din = 1'b0; k = cyc + 1; tick(2); din = 1'b1;
    expect_ev(c_kind_glitch, k + 4);
    wait_edge(k + 4); check("t3_level_glitch", level, 1);
    tick(4);

    // Sustained low is accepted
    din = 1'b0; k = cyc + 1;
    expect_fall(k + 6);
    wait_edge(k + 5); check("t3_level_pre",  level, 1);
    wait_edge(k + 6); check("t3_level_post", level, 0);
    tick(3);

    // High for 3 and 4 samples: both abort
    din = 1'b1; k = cyc + 1; tick(3); din = 1'b0;
    expect_ev(c_kind_glitch, k + 5);
    wait_edge(k + 5); check("t2_level_g3", level, 0);
    tick(3);
    din = 1'b1; k = cyc + 1; tick(4); din = 1'b0;
    expect_ev(c_kind_glitch, k + 6);
    wait_edge(k + 6); check("t2_level_g4", level, 0);
    tick(3);

    // High for 5 samples: the shortest accepted pulse
    din = 1'b1; k = cyc + 1; tick(5); din = 1'b0;
    expect_ev(c_kind_rise, k + 6);
    expect_fall(k + 11);
    wait_edge(k + 6);  check("b5_level_rise", level, 1);
    wait_edge(k + 10); check("b5_level_hold", level, 1);
    wait_edge(k + 11); check("b5_level_fall", level, 0);
    tick(3);

    // Square wave: 5 periods of 20 clk
    r0 = rise_cnt;
    for (int p = 0; p < 5; p++) begin
      din = 1'b1; k = cyc + 1;
      expect_ev(c_kind_rise, k + 6);
      tick(10);
      din = 1'b0;
      expect_fall(k + 16);
      tick(10);
    end
    tick(2);
    check("sq_rises", rise_cnt - r0, 5);
    check("sq_level", level, 0);

    // enb dropped mid-confirm, then re-enabled with din high
    din = 1'b1; k = cyc + 1;
    wait_edge(k + 3); enb = 1'b0;
    wait_edge(k + 4);
    check("t5_off_level", level, 0);
    check("t5_off_rise",  rise,  0);
    wait_edge(k + 5); enb = 1'b1;
    expect_ev(c_kind_rise, k + 12);
    wait_edge(k + 11); check("t5_level_pre",  level, 0);
    wait_edge(k + 12); check("t5_level_post", level, 1);
    tick(2);
    // enb dropped while high clears level on the next edge
    enb = 1'b0; k = cyc + 1;
    wait_edge(k); check("t5_high_off_level", level, 0);
    enb = 1'b1; k = cyc + 1;
    expect_ev(c_kind_rise, k + 6);
    wait_edge(k + 6); check("t5_reen_level", level, 1);
    tick(2);
    din = 1'b0; k = cyc + 1;
    expect_fall(k + 6);
    wait_edge(k + 6); check("t5_fall_level", level, 0);
    tick(3);

    // Asynchronous reset mid-confirm: no pulse, fresh window afterwards
    din = 1'b1; k = cyc + 1;
    wait_edge(k + 3);
    #2 rst_n = 1'b0;
    #1 check("t6_conf_level", level, 0);
    check("t6_conf_rise", rise, 0);
    tick(2);
    rst_n = 1'b1; k = cyc + 1;
    expect_ev(c_kind_rise, k + 6);
    wait_edge(k + 5); check("t6_level_pre",  level, 0);
    wait_edge(k + 6); check("t6_level_post", level, 1);
    tick(2);

    // Asynchronous reset while high clears level without a clock edge
    #2 rst_n = 1'b0;
    #1 check("t6_async_level", level, 0);
    tick(1);
    rst_n = 1'b1; k = cyc + 1;
    expect_ev(c_kind_rise, k + 6);
    wait_edge(k + 6); check("t6_again_level", level, 1);
    din = 1'b0; k = cyc + 1;
    expect_fall(k + 6);
    wait_edge(k + 6); check("t6_final_level", level, 0);
    tick(5);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
